// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, constants and byte-lane merge helper for dmem_wait_ctrl
package dmem_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int LAT_W    = 3;
  // Merge is done at a fixed maximum width; callers extend and truncate to DATA_W.
  localparam int MERGE_W  = 1024;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_BE-1:0] lane_en
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_BE; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with byte-lane write and registered read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_be,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_idx] <= DATA_W'(be_merge(MERGE_W'(r_mem[i_idx]), MERGE_W'(i_wdata), MERGE_BE'(i_be)));
    if (i_re)
      o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// rtl/dmem_wait_ctrl.sv - data memory with req/ack handshake, programmable wait states and range check
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 16,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                wrtd,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   Din,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                ack,
  output logic [DATA_W-1:0]   DataOut,
  output logic                err
);

  localparam bit ZERO_LAT = (LATENCY == 0);

  state_t              r_state;
  logic [LAT_W-1:0]    r_cnt;
  logic                r_wrtd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W/8-1:0] r_be;
  logic                r_ack;
  logic                r_err;
  logic                r_dout_zero;

  logic                w_fire;
  logic                w_acc_wrtd;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_din;
  logic [DATA_W/8-1:0] w_acc_be;
  logic                w_oor;
  logic [DATA_W-1:0]   w_rdata;

  // With zero latency the access uses the live request on its accept edge.
  assign w_fire     = rst_n && (ZERO_LAT ? (r_state == IDLE && req)
                                         : (r_state == WAIT && r_cnt == '0));
  assign w_acc_wrtd = ZERO_LAT ? wrtd    : r_wrtd;
  assign w_acc_addr = ZERO_LAT ? address : r_addr;
  assign w_acc_din  = ZERO_LAT ? Din     : r_din;
  assign w_acc_be   = ZERO_LAT ? be      : r_be;
  assign w_oor      = |w_acc_addr[ADDR_W-1:DEPTH_LOG2];

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .i_we    (w_fire && w_acc_wrtd && !w_oor),
    .i_re    (w_fire && !w_acc_wrtd && !w_oor),
    .i_idx   (w_acc_addr[DEPTH_LOG2-1:0]),
    .i_wdata (w_acc_din),
    .i_be    (w_acc_be),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wrtd      <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_be        <= '0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dout_zero <= 1'b1;
    end else begin
      r_ack <= w_fire;
      r_err <= w_fire && w_oor;
      // Storage read register is never reset, so DataOut is masked until a real read lands.
      if (w_fire && !w_acc_wrtd) r_dout_zero <= w_oor;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_wrtd <= wrtd;
            r_addr <= address;
            r_din  <= Din;
            r_be   <= be;
            if (!ZERO_LAT) begin
              r_cnt   <= LAT_W'(LATENCY - 1);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign ack     = r_ack;
  assign err     = r_err;
  assign DataOut = r_dout_zero ? '0 : w_rdata;

endmodule
